// File: rtl/pipelined_rc_addsub_if.sv
// rtl/pipelined_rc_addsub_if.sv - operand/result handshake bundle for pipelined_rc_addsub
//
// Signals:
//   in_valid, in_ready   operand handshake (producer -> block)
//   A, B, Cin, Sub       operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid, out_ready result handshake (block -> consumer)
//   S, Cout, Ovf         sum/difference, carry-out (no-borrow when subtracting), signed overflow
// Modports:
//   master  producer/consumer side that drives operands and out_ready
//   slave   the adder/subtractor itself

interface pipelined_rc_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, S, Cout, Ovf
    );
endinterface

// File: rtl/pipelined_rc_addsub.sv
// rtl/pipelined_rc_addsub.sv - pipelined ripple-carry adder/subtractor, carry registered every SEG bits
//
// Parameters:
//   WIDTH  operand/result width, a multiple of SEG
//   SEG    bits per pipeline segment; NSEG = WIDTH/SEG stages
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   bus    pipelined_rc_addsub_if.slave: operand handshake in, result handshake out

module pipelined_rc_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input logic                   clk,
    input logic                   rst,
    pipelined_rc_addsub_if.slave  bus
);
    localparam int NSEG = WIDTH / SEG;

    logic en;
    logic out_valid;

    // One SEG-bit ripple-carry segment; returns {carry_out, sum}.
    function automatic logic [SEG:0] rc_add(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           ci
    );
        logic [SEG-1:0] s;
        logic           c;
        c = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        return {c, s};
    endfunction

    // The whole pipe advances together; a held result freezes every stage.
    assign en           = ~out_valid | bus.out_ready;
    assign bus.in_ready = en;

    genvar k;
    for (k = 0; k < NSEG; k++) begin : g_stage
        localparam int S_W  = (k + 1) * SEG;           // result bits settled after this stage
        localparam int HI_W = WIDTH - (k + 1) * SEG;   // operand bits still waiting for their stage

        logic [SEG-1:0] a_seg;
        logic [SEG-1:0] b_seg;
        logic           c_in;
        logic           v_in;
        logic [SEG:0]   add_r;
        logic [S_W-1:0] s_next;

        logic           v_q;
        logic           c_q;
        logic [S_W-1:0] s_q;

        if (k == 0) begin : g_head
            // Subtract is folded in here: A + ~B + ~Cin. Nothing downstream sees Sub.
            assign a_seg  = bus.A[SEG-1:0];
            assign b_seg  = bus.B[SEG-1:0] ^ {SEG{bus.Sub}};
            assign c_in   = bus.Cin ^ bus.Sub;
            assign v_in   = bus.in_valid;
            assign s_next = add_r[SEG-1:0];
        end else begin : g_body
            // Skewed operands arrive right-aligned, so the next segment is always the low SEG bits.
            assign a_seg  = g_stage[k-1].g_skew.a_q[SEG-1:0];
            assign b_seg  = g_stage[k-1].g_skew.b_q[SEG-1:0];
            assign c_in   = g_stage[k-1].c_q;
            assign v_in   = g_stage[k-1].v_q;
            // Lower result segments ride along (deskew) so all of S leaves together.
            assign s_next = {add_r[SEG-1:0], g_stage[k-1].s_q};
        end

        assign add_r = rc_add(a_seg, b_seg, c_in);

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_in;
                c_q <= add_r[SEG];
                s_q <= s_next;
            end
        end

        if (k < NSEG - 1) begin : g_skew
            logic [HI_W-1:0] a_ld;
            logic [HI_W-1:0] b_ld;
            logic [HI_W-1:0] a_q;
            logic [HI_W-1:0] b_q;

            if (k == 0) begin : g_from_in
                assign a_ld = bus.A[WIDTH-1:SEG];
                assign b_ld = bus.B[WIDTH-1:SEG] ^ {HI_W{bus.Sub}};
            end else begin : g_from_prev
                // Drop the segment consumed by this stage.
                assign a_ld = g_stage[k-1].g_skew.a_q[HI_W+SEG-1:SEG];
                assign b_ld = g_stage[k-1].g_skew.b_q[HI_W+SEG-1:SEG];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_ld;
                    b_q <= b_ld;
                end
            end
        end else begin : g_tail
            logic ovf_q;

            // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c_msb.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= a_seg[SEG-1] ^ b_seg[SEG-1] ^ add_r[SEG-1] ^ add_r[SEG];
                end
            end
        end
    end

    assign out_valid     = g_stage[NSEG-1].v_q;
    assign bus.out_valid = out_valid;
    assign bus.S         = g_stage[NSEG-1].s_q;
    assign bus.Cout      = g_stage[NSEG-1].c_q;
    assign bus.Ovf       = g_stage[NSEG-1].g_tail.ovf_q;

endmodule

// File: doc/pipelined_rc_addsub.md
# pipelined_rc_addsub

Parametrised, pipelined ripple-carry adder/subtractor for the arithmetic datapath. It generalises the team's fixed 4-bit ripple-carry adder in three ways:
- arbitrary operand width;
- an add/subtract mode;
- carry chain registered every SEG bits, so width no longer limits clock rate.

Operands enter through a valid/ready handshake and results leave through one, so the block drops directly between producer and consumer stages. It accepts one operation per cycle.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, bits per pipeline segment; NSEG = WIDTH/SEG stages, NSEG ≥ 1.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept operands this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in in add mode, borrow-in in subtract mode.
- Sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- S  output  WIDTH  sum/difference.
- Cout  output  1  carry-out; in subtract mode 1 = no borrow.
- Ovf  output  1  two's-complement signed overflow.

## Operation
- Arithmetic:
  - Add: S, Cout = A + B + Cin.
  - Subtract: S, Cout = A + ~B + ~Cin, i.e. A − B − Cin.
  - Inversion of B and Cin is applied at input capture; Sub is not carried down the pipe.
  - Ovf = carry into MSB XOR carry out of MSB.
- Pipeline structure:
  - Stage k (0..NSEG−1) adds segment k, bits [k·SEG +: SEG], using the registered carry from stage k−1; stage 0 uses the effective Cin.
  - Upper operand segments are delayed (skewed) so each arrives at its stage together with its carry.
  - Lower result segments are delayed (deskewed) so all of S emerges in the same cycle.
- Each stage holds a valid bit; bubbles travel through the pipe and are not squeezed out.
- Global advance enable: en = ~out_valid | out_ready.
  - in_ready = en.
  - All stage registers, including the valid bits, update only when en = 1.
- Operand transfer occurs when in_valid & in_ready. When in_ready = 1 and in_valid = 0, a bubble (valid = 0) is inserted.
- Result transfer occurs when out_valid & out_ready.
- S, Cout and Ovf are registered and held stable while out_valid & ~out_ready.
- No combinational path from in_valid, A, B, Cin or Sub to any output. in_ready is combinational from out_ready only.

## Timing
- Reset values: out_valid = 0, S = 0, Cout = 0, Ovf = 0, all stage valid bits = 0.
- in_ready is 1 in the first cycle after reset.
- rst asserted mid-operation discards all in-flight operations. No result for them ever appears.
- Latency: an operation accepted at edge t produces out_valid = 1 after edge t+NSEG−1, when there are no stalls.
  - WIDTH = 16, SEG = 4: visible 4 cycles after the cycle of acceptance.
  - NSEG = 1: registered in one cycle.
- Throughput: one operation per cycle while out_ready = 1.
- Stall:
  - out_ready = 0 with out_valid = 1 freezes the whole pipe and drives in_ready = 0 in the same cycle.
  - Release resumes with no loss, duplication or reordering.
- Simultaneous output and input transfer in one cycle is allowed and is the steady-state case.
- Cin and Sub are sampled only on the accepting edge.

## Test plan
All cases use WIDTH = 16, SEG = 4.
- Add 0xFFFF + 0x0001, Cin = 0, Sub = 0 -> S = 0x0000, Cout = 1, Ovf = 0, out_valid 4 cycles after acceptance.
- Add 0x7FFF + 0x0001, Cin = 0 -> S = 0x8000, Cout = 0, Ovf = 1; add 0x1234 + 0x0FFF, Cin = 1 -> S = 0x2234, Cout = 0, Ovf = 0 (carry crosses every segment boundary).
- Subtract 0x0005 − 0x0007, Cin = 0 -> S = 0xFFFE, Cout = 0, Ovf = 0; subtract 0x8000 − 0x0001 -> S = 0x7FFF, Cout = 1, Ovf = 1.
- 8 back-to-back operations with out_ready low for 3 cycles mid-stream -> in_ready low exactly those cycles, S held stable, all 8 results in order, none lost or duplicated.
- in_valid toggled 1, 0, 1, 0 -> results appear with matching bubble spacing; every output checked against a reference model.
- rst asserted with 3 operations in flight -> next cycle out_valid = 0, S = 0, Cout = 0, Ovf = 0, in_ready = 1; none of the 3 results ever emerge.
